// File: rtl/sw_event_encoder_if.sv
// Pin-side and event-side signals of the switch/key panel conditioner.
// master = the encoder (drives the debounced levels and event stream).
interface sw_event_encoder_if;
   logic       KEY0;
   logic [4:0] SW;
   logic       EVT_VALID;
   logic [2:0] EVT_CODE;
   logic       KEY_DB;
   logic [4:0] SW_DB;
   logic       EVT_OVERRUN;

   modport master (input KEY0, SW, output EVT_VALID, EVT_CODE, KEY_DB, SW_DB, EVT_OVERRUN);
   modport slave  (output KEY0, SW, input EVT_VALID, EVT_CODE, KEY_DB, SW_DB, EVT_OVERRUN);
endinterface

// File: rtl/sw_event_encoder.sv
// Synchronize, debounce and priority-serialize KEY0/SW[4:0] press edges into 3-bit events.
// Define SW_EVT_BYPASS_DEBOUNCE_EN to compile out the debounce counters (stable follows sync2).
module sw_event_lane #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic CLK,
   input  logic RESET,
   input  logic raw,
   output logic stable,
   output logic rise
);
   logic [1:0] sync;
   logic       take;

`ifdef SW_EVT_BYPASS_DEBOUNCE_EN
   assign take = (sync[1] != stable);
`else
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [CNT_W-1:0] cnt;

   assign take = (sync[1] != stable) && (cnt == CNT_MAX);

   // Any return to the stable level restarts the count, filtering bounces.
   always_ff @(posedge CLK) begin
      if (RESET)                         cnt <= '0;
      else if (sync[1] == stable || take) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
   end
`endif

   // Asserted in the cycle whose closing edge moves stable 0->1.
   assign rise = take & sync[1];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync   <= '0;
         stable <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (take) stable <= sync[1];
      end
   end
endmodule

module sw_event_encoder #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter bit ACTIVE_LOW_KEY  = 1'b1
) (
   input logic               CLK,
   input logic               RESET,
   sw_event_encoder_if.master io
);
   localparam int NUM_LANES = 6;

   typedef struct packed {
      logic       valid;
      logic [2:0] code;
   } evt_t;

   logic [NUM_LANES-1:0] raw, stable, rise, pending, grant;
   logic [2:0]           code;
   logic                 overrun_hit;
   evt_t                 evt_q;
   logic                 overrun_q;

   // Lane 0 is the key, lanes 1..5 are SW0..SW4, so lane index equals event code.
   assign raw = {io.SW, (ACTIVE_LOW_KEY ? ~io.KEY0 : io.KEY0)};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      sw_event_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_lane (
         .CLK    (CLK),
         .RESET  (RESET),
         .raw    (raw[i]),
         .stable (stable[i]),
         .rise   (rise[i])
      );
   end

   always_comb begin
      grant = '0;
      code  = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (pending[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            code     = 3'(i);
         end
      end
   end

   assign overrun_hit = |(rise & pending & ~grant);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pending   <= '0;
         evt_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         // Set wins over clear so a re-arm during emission is kept.
         pending     <= (pending & ~grant) | rise;
         evt_q.valid <= |pending;
         if (|pending) evt_q.code <= code;
         if (overrun_hit) overrun_q <= 1'b1;
      end
   end

   assign io.EVT_VALID   = evt_q.valid;
   assign io.EVT_CODE    = evt_q.code;
   assign io.EVT_OVERRUN = overrun_q;
   assign io.KEY_DB      = stable[0];
   assign io.SW_DB       = stable[NUM_LANES-1:1];
endmodule

// File: doc/sw_event_encoder.md
# sw_event_encoder

- Front-end input conditioner for the switch/key panel.
- Synchronizes and debounces raw KEY0 and SW[4:0] from the board pins.
- Turns debounced press edges into a serialized stream of 3-bit event codes with a one-cycle valid strobe.
- Sits between the board pins and the panel state machine, so the FSM consumes clean single-cycle events instead of raw levels.

## Interface
- DEBOUNCE_CYCLES, 50000: clocks a synchronized input must differ from its stable level before the change is accepted; legal range 1..2^CNT_W.
- CNT_W, 16: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- ACTIVE_LOW_KEY, 1: 1 means KEY0 is pressed when low; 0 means pressed when high.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- KEY0  in  1  raw pushbutton, asynchronous.
- SW  in  5  raw slide switches SW[4:0], asynchronous.
- EVT_VALID  out  1  one-cycle strobe; EVT_CODE is valid while high.
- EVT_CODE  out  3  event code: 0 = KEY0 press, 1..5 = rising edge of SW0..SW4; 6 and 7 are never produced.
- KEY_DB  out  1  debounced KEY0, 1 = pressed.
- SW_DB  out  5  debounced switch levels.
- EVT_OVERRUN  out  1  sticky flag: an event was lost; cleared only by RESET.

## Operation
- Polarity: KEY0 is converted to active-high per ACTIVE_LOW_KEY before synchronization.
- Synchronizer: the six inputs (key + 5 switches) each pass through a 2-flop synchronizer, giving sync2[i].
- Debounce, per input i (independent counter and stable bit):
  - sync2 == stable: cnt <= 0.
  - sync2 != stable and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - If the input bounces back before the count completes, cnt resets to 0 and nothing changes.
- Edge capture: when stable goes 0->1 on an edge, pending[i] is set on that same edge. Falling edges update KEY_DB/SW_DB only and generate no event.
- Arbiter: each cycle with pending != 0, the highest-priority pending bit is emitted and cleared.
  - Priority: KEY0 first, then SW0, SW1, ... SW4 last.
  - Emission: EVT_VALID <= 1 and EVT_CODE <= code on the next edge; otherwise EVT_VALID <= 0.
  - A bit cleared in the same cycle it is re-set stays set, so no loss occurs.
  - At most one event per cycle. Simultaneous edges drain on consecutive cycles in priority order.
- Overrun: a new rising edge on input i while pending[i] is already set and not being emitted that cycle sets EVT_OVERRUN. The duplicate event is dropped (pending stays a single bit).
- No handshake and no backpressure: the consumer must accept every EVT_VALID cycle.
- Inputs active at reset release: stable resets to 0, so a switch held high (or key held pressed) through reset produces its event after the normal debounce delay.

## Timing
- Reset (synchronous, active-high), on any edge with RESET=1:
  - Clears sync flops, stable bits, counters, pending, EVT_OVERRUN.
  - Outputs: EVT_VALID=0, EVT_CODE=0, KEY_DB=0, SW_DB=0, EVT_OVERRUN=0.
  - Reset mid-debounce or mid-drain discards all in-flight work.
- Lone event latency, raw change settled before edge 1:
  - sync2 valid at edge 2.
  - stable/SW_DB/KEY_DB update at edge 2+DEBOUNCE_CYCLES.
  - EVT_VALID high after edge 3+DEBOUNCE_CYCLES, for exactly one cycle.
- N simultaneous rising edges: events occupy N consecutive cycles starting at the lone-event latency.
- Minimum accepted pulse width: DEBOUNCE_CYCLES clocks of settled synchronized level; shorter pulses are filtered.

## Configuration
- SW_EVT_BYPASS_DEBOUNCE_EN defined (simulation/bring-up):
  - Debounce counters are compiled out.
  - stable loads sync2 on every edge; behaviour is identical to DEBOUNCE_CYCLES=1 (event latency 4 clocks) regardless of the parameter.
- Undefined: full debounce as specified above.

## Test plan
- DEBOUNCE_CYCLES=4, after reset, raise SW[1] and hold -> SW_DB[1]=1 after edge 6; single EVT_VALID pulse with EVT_CODE=2 after edge 7; no further events.
- DEBOUNCE_CYCLES=4, SW[2] toggles every 2 clocks for 12 clocks then holds high -> exactly one event, EVT_CODE=3, 7 clocks after the final transition.
- DEBOUNCE_CYCLES=4, same cycle: KEY0 driven 0 (ACTIVE_LOW_KEY=1), SW[3] and SW[0] raised -> EVT_CODE 0, 1, 4 on three consecutive EVT_VALID cycles; EVT_OVERRUN stays 0.
- DEBOUNCE_CYCLES=1: all six inputs rise together, then SW[4] falls for 1 clock and rises again while pending[4] is still queued -> EVT_OVERRUN=1; exactly one code-5 event emitted (last in the sequence); flag clears only on RESET.
- DEBOUNCE_CYCLES=4: SW[4] raised, RESET pulsed 2 clocks later -> no event; SW_DB=0 during reset; code-5 event appears 7 clocks after the first edge with RESET low.
- SW_EVT_BYPASS_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=50000: 1-clock-wide-settled SW[1] pulse -> EVT_CODE=2 after edge 4; SW_DB[1] pulses for 1 cycle.
